// File: rtl/blut_loader.sv
// Branch lookup table loader: streams target words from a valid/ready source,
// adds a program base offset, and writes them into a combinationally-read table.
module blut_loader #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             init,
  input  logic             start,
  input  logic [IDX_W-1:0] base_idx,
  input  logic [IDX_W:0]   count,
  input  logic [PC_W-1:0]  offset,
  input  logic             cfg_valid,
  input  logic [PC_W-1:0]  cfg_data,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] lk_idx,
  output logic [PC_W-1:0]  lk_target,
  output logic             busy,
  output logic             done
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [IDX_W:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  state_t           state;
  logic [PC_W-1:0]  tbl [ENTRIES];
  logic [IDX_W-1:0] base_q;
  logic [IDX_W:0]   count_q;
  logic [IDX_W:0]   n_q;
  logic [PC_W-1:0]  offset_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [IDX_W-1:0] wr_idx;
  logic             last_word;

  // Index arithmetic wraps naturally at IDX_W bits, so base+n is already mod 2**IDX_W.
  assign wr_idx    = base_q + n_q[IDX_W-1:0];
  assign last_word = (n_q == (count_q - ONE));

  assign lk_target = tbl[lk_idx];
  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (init) begin
      state    <= IDLE;
      base_q   <= '0;
      count_q  <= '0;
      n_q      <= '0;
      offset_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (count != '0) begin
              base_q   <= base_idx;
              count_q  <= count;
              offset_q <= offset;
              n_q      <= '0;
              ready_q  <= 1'b1;
              state    <= LOAD;
            end else begin
              done_q <= 1'b1;
              state  <= FIN;
            end
          end
        end
        LOAD: begin
          // Stalled cycles (cfg_valid low) leave every register untouched.
          if (cfg_valid) begin
            tbl[wr_idx] <= cfg_data + offset_q;
            n_q         <= n_q + ONE;
            if (last_word) begin
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= FIN;
            end
          end
        end
        FIN: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blut_loader.sv
// Self-checking bench for blut_loader: drives loads with directed and random
// words and compares the table and handshake outputs to an array-based model.
module tb_blut_loader;

  localparam int PC_W  = 8;
  localparam int IDX_W = 5;
  localparam int N     = 32;

  logic             clk;
  logic             init;
  logic             start;
  logic [IDX_W-1:0] base_idx;
  logic [IDX_W:0]   count;
  logic [PC_W-1:0]  offset;
  logic             cfg_valid;
  logic [PC_W-1:0]  cfg_data;
  logic             cfg_ready;
  logic [IDX_W-1:0] lk_idx;
  logic [PC_W-1:0]  lk_target;
  logic             busy;
  logic             done;

  int checks = 0;
  int passed = 0;

  logic [PC_W-1:0] model [N];
  logic [PC_W-1:0] words [$];

  blut_loader #(.PC_W(PC_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .init      (init),
    .start     (start),
    .base_idx  (base_idx),
    .count     (count),
    .offset    (offset),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .lk_idx    (lk_idx),
    .lk_target (lk_target),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  // Reads every table entry through the lookup port and compares it to the model.
  task automatic verify_table(input string tag);
    for (int i = 0; i < N; i++) begin
      lk_idx = 5'(i);
      #1;
      checks++;
      if (lk_target !== model[i])
        $display("[TB] FAIL %s entry %0d: got %0d expected %0d", tag, i, lk_target, model[i]);
      else
        passed++;
    end
  endtask

  // Runs one load from IDLE; vmode 0 = valid held, 1 = valid every other cycle, 2 = random.
  // A poke cycle >= 0 issues a stray start pulse with different parameters mid-load.
  task automatic run_load(input int b, input int cnt, input int off, input int vmode, input int poke);
    int acc;
    int cyc;
    int idx;
    logic v;
    start    = 1'b1;
    base_idx = 5'(b);
    count    = 6'(cnt);
    offset   = 8'(off);
    tick();
    start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < cnt) begin
      checks++;
      if ({cfg_ready, busy, done} !== 3'b110)
        $display("[TB] FAIL load_flags cyc %0d: got %b expected 110", cyc, {cfg_ready, busy, done});
      else
        passed++;
      if (vmode == 0) v = 1'b1;
      else if (vmode == 1) v = (cyc % 2 == 0);
      else v = 1'($urandom_range(0, 1));
      if (cyc == poke) begin
        start    = 1'b1;
        base_idx = 5'(b + 7);
        count    = 6'd1;
        offset   = 8'(off + 1);
      end
      cfg_valid = v;
      cfg_data  = words[acc];
      tick();
      start     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = 8'($urandom);
      if (v) begin
        idx = (b + acc) % N;
        model[idx] = 8'((int'(words[acc]) + off) % 256);
        lk_idx = 5'(idx);
        #1;
        checks++;
        if (lk_target !== model[idx])
          $display("[TB] FAIL write_order acc %0d idx %0d: got %0d expected %0d", acc, idx, lk_target, model[idx]);
        else
          passed++;
        acc++;
      end
      cyc++;
      if (cyc > 2000) begin
        checks++;
        $display("[TB] FAIL load_timeout: got %0d accepts expected %0d", acc, cnt);
        break;
      end
    end
    checks++;
    if ({cfg_ready, busy, done} !== 3'b011)
      $display("[TB] FAIL fin_flags: got %b expected 011", {cfg_ready, busy, done});
    else
      passed++;
    tick();
    checks++;
    if ({cfg_ready, busy, done} !== 3'b000)
      $display("[TB] FAIL idle_flags: got %b expected 000", {cfg_ready, busy, done});
    else
      passed++;
  endtask

  task automatic test_reset();
    init = 1'b1;
    tick();
    init = 1'b0;
    clear_model();
    checks++;
    if ({cfg_ready, busy, done} !== 3'b000)
      $display("[TB] FAIL reset_flags: got %b expected 000", {cfg_ready, busy, done});
    else
      passed++;
    verify_table("reset");
  endtask

  task automatic test_basic();
    words = '{8'd53, 8'd11, 8'd99, 8'd57};
    run_load(0, 4, 0, 0, -1);
    verify_table("basic");
  endtask

  task automatic test_toggle();
    logic [PC_W-1:0] want [8];
    want  = '{8'd202, 8'd192, 8'd137, 8'd126, 8'd251, 8'd206, 8'd111, 8'd104};
    words = '{8'd103, 8'd93, 8'd38, 8'd27, 8'd152, 8'd107, 8'd12, 8'd5};
    run_load(4, 8, 99, 1, -1);
    for (int i = 0; i < 8; i++) begin
      lk_idx = 5'(4 + i);
      #1;
      checks++;
      if (lk_target !== want[i])
        $display("[TB] FAIL toggle_const entry %0d: got %0d expected %0d", 4 + i, lk_target, want[i]);
      else
        passed++;
    end
    verify_table("toggle");
  endtask

  task automatic test_pc_wrap();
    words = '{8'd239};
    run_load(12, 1, 99, 0, -1);
    lk_idx = 5'd12;
    #1;
    checks++;
    if (lk_target !== 8'd82)
      $display("[TB] FAIL pc_wrap: got %0d expected 82", lk_target);
    else
      passed++;
  endtask

  task automatic test_index_wrap();
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back(8'($urandom));
    run_load(30, 4, 17, 0, 1);
    verify_table("index_wrap");
  endtask

  task automatic test_zero_count();
    run_load(9, 0, 55, 0, -1);
    verify_table("zero_count");
  endtask

  task automatic test_same_cycle();
    logic [PC_W-1:0] w;
    w        = 8'($urandom);
    start    = 1'b1;
    base_idx = 5'd20;
    count    = 6'd1;
    offset   = 8'd3;
    tick();
    start     = 1'b0;
    lk_idx    = 5'd20;
    cfg_valid = 1'b1;
    cfg_data  = w;
    #1;
    checks++;
    if (lk_target !== model[20])
      $display("[TB] FAIL same_cycle_old: got %0d expected %0d", lk_target, model[20]);
    else
      passed++;
    tick();
    cfg_valid = 1'b0;
    model[20] = 8'((int'(w) + 3) % 256);
    checks++;
    if (lk_target !== model[20])
      $display("[TB] FAIL same_cycle_new: got %0d expected %0d", lk_target, model[20]);
    else
      passed++;
    tick();
  endtask

  task automatic test_init_midload();
    start    = 1'b1;
    base_idx = 5'd0;
    count    = 6'd4;
    offset   = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'($urandom);
      tick();
    end
    init      = 1'b1;
    start     = 1'b1;
    cfg_valid = 1'b1;
    tick();
    init      = 1'b0;
    start     = 1'b0;
    cfg_valid = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cfg_ready, busy, done} !== 3'b000)
        $display("[TB] FAIL abort_flags cyc %0d: got %b expected 000", i, {cfg_ready, busy, done});
      else
        passed++;
      tick();
    end
    verify_table("abort");
    test_basic();
  endtask

  task automatic test_full();
    int b;
    int o;
    b = $urandom_range(0, N - 1);
    o = $urandom_range(0, 255);
    words.delete();
    for (int i = 0; i < N; i++) words.push_back(8'($urandom));
    run_load(b, N, o, 2, -1);
    verify_table("full");
  endtask

  task automatic test_random();
    int b;
    int c;
    for (int r = 0; r < 6; r++) begin
      b = $urandom_range(0, N - 1);
      c = $urandom_range(0, N);
      words.delete();
      for (int i = 0; i < c; i++) words.push_back(8'($urandom));
      run_load(b, c, $urandom_range(0, 255), 2, $urandom_range(0, 3));
    end
    verify_table("random");
  endtask

  initial begin
    init      = 1'b1;
    start     = 1'b0;
    base_idx  = '0;
    count     = '0;
    offset    = '0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    lk_idx    = '0;
    clear_model();
    test_reset();
    test_basic();
    test_toggle();
    test_pc_wrap();
    test_index_wrap();
    test_zero_count();
    test_same_cycle();
    test_init_midload();
    test_full();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/blut_loader.md
BLUT_LOADER -- requirements
Module: blut_loader

Interface
REQ-001 SHALL have parameter PC_W, default 10, giving the branch-target (program counter) width.
REQ-002 SHALL have parameter IDX_W, default 5, giving the table index width (2**IDX_W entries).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port init, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a table load.
REQ-006 SHALL have port base_idx, input, IDX_W, the first table entry to write; sampled on start.
REQ-007 SHALL have port count, input, IDX_W+1, the number of entries to write (0..2**IDX_W); sampled on start.
REQ-008 SHALL have port offset, input, PC_W, the program base added to every loaded target; sampled on start.
REQ-009 SHALL have port cfg_valid, input, 1, meaning the source presents a target word.
REQ-010 SHALL have port cfg_data, input, PC_W, the raw target word.
REQ-011 SHALL have port cfg_ready, output, 1, meaning the block accepts cfg_data this cycle.
REQ-012 SHALL have port lk_idx, input, IDX_W, the lookup index, normally the regB value from the datapath.
REQ-013 SHALL have port lk_target, output, PC_W, the table contents at lk_idx.
REQ-014 SHALL have port busy, output, 1, high while a load is in progress.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse when a load completes.

Function
REQ-016 SHALL hold 2**IDX_W entries of PC_W bits each, with one write port and one combinational read port.
REQ-017 SHALL drive lk_target combinationally from the table at lk_idx, with zero-cycle latency, in every state.
REQ-018 SHALL implement FSM states IDLE, LOAD and FIN.
REQ-019 SHALL, in IDLE when start=1 and count>0, latch base_idx, count and offset, clear the entry counter and go to LOAD.
REQ-020 SHALL, in IDLE when start=1 and count=0, go directly to FIN and write no entries.
REQ-021 SHALL drive cfg_ready=1 only in LOAD.
REQ-022 SHALL, on each LOAD cycle with cfg_valid=1, write cfg_data+offset, modulo 2**PC_W with the carry discarded, to entry (base+n) mod 2**IDX_W, where n is the entry counter, and then increment n.
REQ-023 SHALL hold all state unchanged on LOAD cycles with cfg_valid=0.
REQ-024 SHALL go from LOAD to FIN in the cycle that accepts the last word (n = count-1).
REQ-025 SHALL assert done=1 for exactly one cycle in FIN and then return to IDLE.
REQ-026 SHALL drive busy=1 in LOAD and FIN, and 0 in IDLE.
REQ-027 SHALL ignore start whenever the state is not IDLE; no error is flagged.
REQ-028 SHALL, when lk_idx equals the entry written in the same cycle, return the old value; the new value is visible the following cycle.
REQ-029 SHALL, when count=2**IDX_W, write every entry exactly once, wrapping from index 2**IDX_W-1 to 0.

Reset
REQ-030 SHALL, when init=1, force the state to IDLE, clear the entry counter and latched parameters, and set every table entry to 0.
REQ-031 SHALL give init priority over start and over cfg_valid in the same cycle.
REQ-032 SHALL drive cfg_ready=0, busy=0, done=0 and lk_target=0 (for any lk_idx) in the first cycle after init.
REQ-033 SHALL, when init is asserted mid-load, abandon the load without a done pulse and leave the table all zero.

Verification
REQ-034 SHALL be verified by: init; start with base=0, count=4, offset=0; words 53, 11, 99, 57 with cfg_valid held high -> entries 0..3 = 53, 11, 99, 57; done pulses in the cycle after the 4th accept; busy high for 5 cycles.
REQ-035 SHALL be verified by: start with base=4, count=8, offset=99; words 103, 93, 38, 27, 152, 107, 12, 5 with cfg_valid toggled every other cycle -> entries 4..11 = 202, 192, 137, 126, 251, 206, 111, 104; entries 0..3 unchanged.
REQ-036 SHALL be verified by: PC_W=8, offset=99, word 239 -> stored value 82 (wrap modulo 256).
REQ-037 SHALL be verified by: base=30, count=4 -> entries 30, 31, 0, 1 written in that order; a start pulse issued mid-load is ignored.
REQ-038 SHALL be verified by: count=0 -> no cfg_ready; done one cycle after start; table unchanged.
REQ-039 SHALL be verified by: init asserted after the 2nd of 4 accepted words -> no done pulse; all lk_target=0; a following fresh load behaves per REQ-034.
